// File: rtl/fp32_to_q15_arbiter.sv
// fp32_to_q15_arbiter: round-robin share of one fp32->Q16.48 converter among NUM_REQ valid/ready requesters, registered id+result response
module fp32_to_q15 (
  input  logic [31:0] f,
  output logic [63:0] q
);
  logic [7:0] e;
  logic [63:0] m, mag;
  always_comb begin
    e = f[30:23];
    m = {40'd0, 1'b1, f[22:0]};
    mag = e >= 8'd102 ? m << (e - 8'd102) : m >> (8'd102 - e);
    q = e == 8'd0 ? 64'd0 : e >= 8'd142 ? (f[31] ? 64'h8000000000000001 : 64'h7FFFFFFFFFFFFFFF) : f[31] ? -mag : mag;
  end
endmodule

module fp32_to_q15_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*32-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [63:0]          rsp_data,
  output logic [31:0]          conv_count
);
  logic [ID_W-1:0] ptr, g;
  logic [ID_W:0] s;
  logic found, can_accept, hs;
  logic [31:0] gnt_data;
  logic [63:0] conv_q;
  always_comb begin
    found = 1'b0;
    g = '0;
    s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      s = {1'b0, ptr} + (ID_W+1)'(k);
      if (s >= (ID_W+1)'(NUM_REQ)) s = s - (ID_W+1)'(NUM_REQ);
      if (!found && req_valid[s[ID_W-1:0]]) begin
        found = 1'b1;
        g = s[ID_W-1:0];
      end
    end
    can_accept = !rsp_valid || rsp_ready;
    req_ready = (found && can_accept && !reset) ? NUM_REQ'(1) << g : '0;
    hs = |(req_valid & req_ready);
    gnt_data = req_data[32*g +: 32];
  end
  fp32_to_q15 u_conv (.f(gnt_data), .q(conv_q));
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_data <= '0;
      conv_count <= '0;
      ptr <= '0;
    end else if (hs) begin
      rsp_valid <= 1'b1;
      rsp_id <= g;
      rsp_data <= conv_q;
      conv_count <= conv_count + 32'd1;
      ptr <= g == ID_W'(NUM_REQ-1) ? '0 : g + 1'b1;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fp32_to_q15_arbiter.sv
// tb_fp32_to_q15_arbiter: scoreboard bench with real-arithmetic reference model for the shared converter arbiter
module tb_fp32_to_q15_arbiter;
  localparam int N = 4;
  logic clk = 0, reset = 1, rsp_ready = 0, rsp_valid;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*32-1:0] req_data = '0;
  logic [1:0] rsp_id;
  logic [63:0] rsp_data;
  logic [31:0] conv_count;
  int checks = 0, errors = 0;
  logic [65:0] sb[$];
  logic [N-1:0] exp_rdy = '0;
  logic m_pend = 0, last_hs = 0, last_rr = 0, done = 0, final_done = 0;
  logic [31:0] m_cnt = '0;
  int m_ptr = 0, last_g = 0;

  fp32_to_q15_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .conv_count(conv_count)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_q(input logic [31:0] w);
    int e;
    real r;
    longint v;
    e = int'(w[30:23]);
    if (e == 255) r = 2.0 ** 64;
    else if (e == 0) r = real'(w[22:0]) * 2.0 ** (-101);
    else r = (8388608.0 + real'(w[22:0])) * 2.0 ** (e - 102);
    v = r >= 2.0 ** 63 ? 64'h7FFFFFFFFFFFFFFF : longint'($floor(r));
    return w[31] ? -v : v;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    int c;
    w = $urandom;
    c = $urandom_range(0, 4);
    if (c == 0) w[30:0] = '0;
    else if (c == 1) w[30:0] = {8'hFF, 23'd0};
    else if (c == 2) w[30:23] = 8'($urandom_range(98, 146));
    else w[30:23] = 8'($urandom_range(0, 254));
    return w;
  endfunction

  function automatic logic [N*32-1:0] rand_data();
    logic [N*32-1:0] d;
    for (int i = 0; i < N; i++) d[32*i +: 32] = rand_word();
    return d;
  endfunction

  task automatic cyc(input logic [N-1:0] v, input logic [N*32-1:0] d, input logic rr);
    int g;
    logic [31:0] w;
    @(posedge clk);
    #1;
    if (last_hs) begin
      m_pend = 1;
      m_ptr = (last_g + 1) % N;
      m_cnt = m_cnt + 1;
    end else if (last_rr) m_pend = 0;
    reset = 0;
    req_valid = v;
    req_data = d;
    rsp_ready = rr;
    g = -1;
    if (!m_pend || rr)
      for (int k = 0; k < N; k++)
        if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    exp_rdy = g < 0 ? '0 : N'(1) << g;
    last_hs = g >= 0;
    last_g = g < 0 ? 0 : g;
    last_rr = rr;
    if (g >= 0) begin
      w = d[32*g +: 32];
      sb.push_back({2'(g), ref_q(w)});
    end
  endtask

  task automatic rst(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      reset = 1;
      req_valid = '1;
      req_data = rand_data();
      rsp_ready = 0;
      exp_rdy = '0;
    end
    m_pend = 0;
    m_ptr = 0;
    m_cnt = '0;
    last_hs = 0;
    last_rr = 0;
    sb.delete();
  endtask

  always @(negedge clk) begin
    checks++;
    if (req_ready !== exp_rdy) begin
      errors++;
      $display("FAIL req_ready got=%b exp=%b t=%0t", req_ready, exp_rdy, $time);
    end
    if (!reset) begin
      checks++;
      if (rsp_valid !== m_pend) begin
        errors++;
        $display("FAIL rsp_valid got=%b exp=%b t=%0t", rsp_valid, m_pend, $time);
      end
      checks++;
      if (conv_count !== m_cnt) begin
        errors++;
        $display("FAIL conv_count got=%0d exp=%0d t=%0t", conv_count, m_cnt, $time);
      end
      if (rsp_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp unexpected id=%0d data=%h t=%0t", rsp_id, rsp_data, $time);
        end else begin
          if ({rsp_id, rsp_data} !== sb[0]) begin
            errors++;
            $display("FAIL rsp got id=%0d data=%h exp id=%0d data=%h t=%0t", rsp_id, rsp_data, sb[0][65:64], sb[0][63:0], $time);
          end
          if (rsp_ready) void'(sb.pop_front());
        end
      end
    end
    if (done && !final_done) begin
      final_done = 1;
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL drain left=%0d exp=0", sb.size());
      end
    end
  end

  initial begin
    logic [N*32-1:0] d;
    rst(2);
    cyc('1, rand_data(), 1);
    cyc('0, '0, 1);
    d = rand_data();
    d[63:32] = 32'h3F800000;
    cyc(4'b0010, d, 1);
    cyc('0, '0, 1);
    for (int i = 0; i < 8; i++) cyc('1, rand_data(), 1);
    for (int i = 0; i < 4; i++) cyc('1, rand_data(), 0);
    cyc('1, rand_data(), 1);
    cyc('0, '0, 1);
    d = rand_data();
    d[95:64] = 32'hFF800000;
    cyc(4'b0100, d, 1);
    d[95:64] = 32'h47000000;
    cyc(4'b0100, d, 1);
    cyc('0, '0, 1);
    cyc('1, rand_data(), 0);
    cyc('1, rand_data(), 0);
    rst(1);
    cyc('1, rand_data(), 1);
    for (int i = 0; i < 400; i++) cyc(N'($urandom), rand_data(), ($urandom % 4) != 0);
    for (int i = 0; i < 3; i++) cyc('0, '0, 1);
    done = 1;
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp32_to_q15_arbiter.md
Name: fp32_to_q15_arbiter

Overview:
Round-robin arbiter that shares one Fp32ToQ15 converter instance among NUM_REQ requesters, such as ray-generation and intersection units that need fixed-point operands. Each requester offers one fp32 word per valid/ready handshake. The arbiter grants at most one requester per cycle and passes its word through the shared converter. The 64-bit signed Q16.48 result is registered and returned with the requester ID on a single valid/ready response channel.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..16.
ID_W, $clog2(NUM_REQ), width of requester ID; localparam, not overridable.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
req_valid  input  NUM_REQ  bit i high: requester i offers a word.
req_data  input  NUM_REQ*32  fp32 word of requester i in bits [32*i+31:32*i].
req_ready  output  NUM_REQ  one-hot-or-zero grant; handshake i completes when req_valid[i] & req_ready[i].
rsp_valid  output  1  response register holds a result.
rsp_ready  input  1  consumer accepts the response.
rsp_id  output  ID_W  index of the requester that produced the response.
rsp_data  output  64  converted value; signed, 16 integer bits, 48 fraction bits.
conv_count  output  32  number of completed request handshakes since reset; wraps at 2^32.

Behaviour:
- Reset (reset high at a clock edge):
  - rsp_valid=0, rsp_id=0, rsp_data=0, conv_count=0.
  - Round-robin pointer=0.
  - While reset is high, req_ready=0 regardless of inputs.
- Slot free: can_accept = ~rsp_valid | rsp_ready. This gives a single-entry output buffer with same-cycle drain-and-refill.
- Grant (combinational):
  - If can_accept=0 or no req_valid bit is set, req_ready=0.
  - Otherwise req_ready has exactly one bit set. It is the first set req_valid bit found by scanning indices ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1.
  - req_ready never depends on rsp_data.
- Datapath: the granted req_data slice drives the single shared Fp32ToQ15 instance. No other converter instances exist.
- On a handshake with granted index g:
  - rsp_data <= converter output.
  - rsp_id <= g.
  - rsp_valid <= 1.
  - ptr <= (g+1) mod NUM_REQ.
  - conv_count <= conv_count+1.
- If rsp_valid & rsp_ready and there is no handshake, rsp_valid <= 0; rsp_data and rsp_id hold their values.
- If rsp_valid & ~rsp_ready:
  - rsp_valid, rsp_id and rsp_data hold stable. This is an AXI-style stability rule.
  - ptr holds; no grant occurs.
- Latency: 1 cycle from request handshake to rsp_valid.
- Throughput: 1 conversion per cycle while rsp_ready stays high.
- Fairness: with all requesters continuously valid, the grant sequence is 0,1,…,NUM_REQ-1,0,…. No requester waits more than NUM_REQ-1 grants.
- Requesters may drop req_valid without a handshake; the arbiter holds no per-requester state.
- Conversion semantics are inherited unchanged from Fp32ToQ15:
  - ±0 -> 0.
  - Truncation toward zero.
  - |x| ≥ 32768 and ±inf saturate to 0x7FFFFFFFFFFFFFFF or 0x8000000000000001.
  - Magnitudes below 2^-48 -> 0.
- Reset mid-operation: a pending response is discarded (rsp_valid=0 next cycle) and ptr returns to 0. No handshake completes in the reset cycle.
- conv_count wraps from 0xFFFFFFFF to 0 without a flag.

Test Plan:
- Reset: hold reset 2 cycles with all req_valid=1 -> req_ready=0 during reset; after release rsp_valid=0, conv_count=0, and the first grant goes to requester 0.
- Single request: only req_valid[1]=1, data 0x3F800000, rsp_ready=1 -> req_ready=4'b0010 that cycle; next cycle rsp_valid=1, rsp_id=1, rsp_data=0x0001000000000000, conv_count=1.
- Round-robin streaming: all 4 valid, rsp_ready=1 for 8 cycles -> grants 0,1,2,3,0,1,2,3 on consecutive cycles, each rsp_id matching one cycle later, conv_count=8.
- Backpressure: rsp_valid=1 and rsp_ready=0 for 3 cycles with requests pending -> req_ready=0 and rsp outputs stable; raise rsp_ready -> the next grant completes in that same cycle and the new response appears the following cycle.
- Saturation: requester 2 sends 0xFF800000 then 0x47000000 -> rsp_data=0x8000000000000001, then 0x7FFFFFFFFFFFFFFF.
- Mid-operation reset: assert reset while rsp_valid=1, rsp_ready=0 -> next cycle rsp_valid=0, conv_count=0; after release with all valid, the first grant is requester 0.
